nibble_serial_adder: RTL and testbench

- Multi-cycle adder/subtractor that computes a WIDTH-bit result with a single fulladder4 slice, time-multiplexed over NIBBLES cycles.
- Sequences the slice least-significant nibble first and registers the carry between nibbles.
- Sits between an issuing unit and a consumer as an area-cheap ALU add path.
- Valid/ready handshake on both the request side and the result side.

---
 rtl/nibble_serial_adder.sv | 120 ++++++++++++
 tb/tb_nibble_serial_adder.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit add/subtract using one 4-bit adder slice, LS nibble first.
// Define NIBBLE_SERIAL_ADDER_FLAGS_EN to add the ovf/zero result flags.

module fulladder4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       ci_i,
  output logic [3:0] s_o,
  output logic       co_o
);
  assign {co_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {4'b0, ci_i};
endmodule

module nibble_serial_adder #(
  parameter int NIBBLES = 4,
  parameter int WIDTH   = 4 * NIBBLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef NIBBLE_SERIAL_ADDER_FLAGS_EN
  ,
  output logic             ovf,
  output logic             zero
`endif
);
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q;
  logic [IDXW-1:0]   idx_q;
  logic              carry_q;
  logic [WIDTH-1:0]  a_q, b_q, sum_q;
  logic              cout_q;
  logic [3:0]        sl_a, sl_b, sl_s;
  logic              sl_co;
  logic              last;

  assign sl_a = a_q[{idx_q, 2'b00} +: 4];
  assign sl_b = b_q[{idx_q, 2'b00} +: 4];
  assign last = (idx_q == IDXW'(NIBBLES - 1));

  fulladder4 u_slice (
    .a_i  (sl_a),
    .b_i  (sl_b),
    .ci_i (carry_q),
    .s_o  (sl_s),
    .co_o (sl_co)
  );

`ifdef NIBBLE_SERIAL_ADDER_FLAGS_EN
  logic ovf_q, zero_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_FLAGS_EN
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          // Subtract is A + ~B + 1: invert B here, inject the +1 as carry-in.
          if (in_valid) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub;
            idx_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q[{idx_q, 2'b00} +: 4] <= sl_s;
          carry_q <= sl_co;
          if (last) begin
            cout_q  <= sl_co;
            idx_q   <= '0;
            state_q <= DONE;
`ifdef NIBBLE_SERIAL_ADDER_FLAGS_EN
            ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sl_s[3] != a_q[WIDTH-1]);
            // Lower nibbles are already final; only the top one arrives this edge.
            zero_q <= (sum_q[WIDTH-5:0] == '0) && (sl_s == 4'h0);
`endif
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed-vector bench for nibble_serial_adder (NIBBLES=4, WIDTH=16).
module tb_nibble_serial_adder;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst, in_valid, out_ready, sub;
  logic [W-1:0] a, b;
  logic         in_ready, out_valid, cout;
  logic [W-1:0] sum;
`ifdef NIBBLE_SERIAL_ADDER_FLAGS_EN
  logic         ovf, zero;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.NIBBLES(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef NIBBLE_SERIAL_ADDER_FLAGS_EN
    ,
    .ovf       (ovf),
    .zero      (zero)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and return once it has been accepted (in RUN cycle 1).
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
    int n;
    a = av; b = bv; sub = sv; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    chk("accept_ready", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  // Wait for the result; returns cycles from accept cycle to first out_valid.
  task automatic wait_result(output int cyc);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    chk("result_timeout", {31'b0, out_valid}, 32'd1);
    cyc = n + 1;
  endtask

  task automatic retire();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("retire_ovalid", {31'b0, out_valid}, 32'd0);
    chk("retire_iready", {31'b0, in_ready}, 32'd1);
  endtask

  task automatic op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                    input logic sv, input logic [W-1:0] es, input logic ec,
                    input logic eovf, input logic ezero);
    int cyc;
    issue(av, bv, sv);
    wait_result(cyc);
    chk({tag, "_lat"}, cyc, N + 1);
    chk({tag, "_sum"}, {16'b0, sum}, {16'b0, es});
    chk({tag, "_cout"}, {31'b0, cout}, {31'b0, ec});
`ifdef NIBBLE_SERIAL_ADDER_FLAGS_EN
    chk({tag, "_ovf"}, {31'b0, ovf}, {31'b0, eovf});
    chk({tag, "_zero"}, {31'b0, zero}, {31'b0, ezero});
`endif
    retire();
  endtask

  initial begin
    int cyc;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sub = 1'b0; a = '0; b = '0;
    tick(); tick();
    chk("rst_iready", {31'b0, in_ready}, 32'd0);
    chk("rst_ovalid", {31'b0, out_valid}, 32'd0);
    chk("rst_sum", {16'b0, sum}, 32'd0);
    chk("rst_cout", {31'b0, cout}, 32'd0);
`ifdef NIBBLE_SERIAL_ADDER_FLAGS_EN
    chk("rst_ovf", {31'b0, ovf}, 32'd0);
    chk("rst_zero", {31'b0, zero}, 32'd0);
`endif
    rst = 1'b0;
    #1;
    chk("rel_iready", {31'b0, in_ready}, 32'd1);

    op("add",  16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0);
    op("wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    op("subn", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    op("subp", 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);

    // Backpressure: result held while a new request waits.
    issue(16'h0003, 16'h0004, 1'b0);
    wait_result(cyc);
    a = 16'h1111; b = 16'h1111; sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_ovalid", {31'b0, out_valid}, 32'd1);
      chk("bp_sum", {16'b0, sum}, 32'h0007);
      chk("bp_iready", {31'b0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_idle_ovalid", {31'b0, out_valid}, 32'd0);
    chk("bp_idle_iready", {31'b0, in_ready}, 32'd1);
    chk("bp_idle_sum", {16'b0, sum}, 32'h0007);
    tick();
    in_valid = 1'b0;
    chk("bp_run_iready", {31'b0, in_ready}, 32'd0);
    wait_result(cyc);
    chk("bp_lat", cyc, N + 1);
    chk("bp_next_sum", {16'b0, sum}, 32'h2222);
    retire();

    // Reset in the second RUN cycle discards the operation.
    issue(16'h1111, 16'h2222, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    chk("mrst_sum", {16'b0, sum}, 32'd0);
    chk("mrst_cout", {31'b0, cout}, 32'd0);
    chk("mrst_ovalid", {31'b0, out_valid}, 32'd0);
    chk("mrst_iready", {31'b0, in_ready}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("mrst_rel_iready", {31'b0, in_ready}, 32'd1);
    op("post", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);

    op("ovfp", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    op("ovfn", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
